// File: rtl/inst_queue_if.sv
// Fetch-to-decode instruction queue bus: fetch group in, two oldest entries out.
// master = fetch/decode side, slave = the queue.
interface inst_queue_if;
   logic         if_valid;
   logic [31:0]  if_pc;
   logic [127:0] if_inst;
   logic [3:0]   if_mask;
   logic [3:0]   if_pred_jump;
   logic [31:0]  if_pred_target;
   logic         if_excp;
   logic         in_ready;

   logic [1:0]   out_valid;
   logic [31:0]  out_pc0;
   logic [31:0]  out_pc1;
   logic [31:0]  out_inst0;
   logic [31:0]  out_inst1;
   logic         out_pred_jump0;
   logic         out_pred_jump1;
   logic [31:0]  out_pred_target0;
   logic [31:0]  out_pred_target1;
   logic         out_excp0;
   logic         out_excp1;
   logic [1:0]   id_pop;

   modport master (
      output if_valid, if_pc, if_inst, if_mask, if_pred_jump, if_pred_target, if_excp, id_pop,
      input  in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
             out_pred_jump0, out_pred_jump1, out_pred_target0, out_pred_target1,
             out_excp0, out_excp1
   );

   modport slave (
      input  if_valid, if_pc, if_inst, if_mask, if_pred_jump, if_pred_target, if_excp, id_pop,
      output in_ready, out_valid, out_pc0, out_pc1, out_inst0, out_inst1,
             out_pred_jump0, out_pred_jump1, out_pred_target0, out_pred_target1,
             out_excp0, out_excp1
   );
endinterface

// File: rtl/inst_queue.sv
// Instruction buffer: compacts valid fetch lanes into a circular FIFO and
// presents the two oldest entries to dual-issue decode.
module inst_queue #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   inst_queue_if.slave   q,
   output logic [CW-1:0] count
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic [31:0] pc_mem   [DEPTH];
   logic [31:0] inst_mem [DEPTH];
   logic [31:0] tgt_mem  [DEPTH];
   logic        pj_mem   [DEPTH];
   logic        excp_mem [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [AW-1:0] head1;
   logic          push;
   logic [2:0]    npush;
   logic [1:0]    npop;
   logic [AW-1:0] lane_idx [4];
   logic [31:0]   lane_pc  [4];
   logic [31:0]   lane_tgt [4];
   logic          unused_pc_lsb;

   assign unused_pc_lsb = ^q.if_pc[3:0];

   assign q.in_ready  = (count <= CW'(DEPTH - 4));
   assign q.out_valid = {count >= CW'(2), count != '0};

   assign push = q.if_valid & q.in_ready & ~flush;
   assign npop = {1'b0, q.id_pop[0] & q.out_valid[0]}
               + {1'b0, q.id_pop[1] & q.id_pop[0] & q.out_valid[1]};

   // Each valid lane lands at tail plus the number of valid lanes below it.
   always_comb begin
      npush = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         lane_idx[i] = tail + AW'(npush);
         npush       = npush + {2'b00, q.if_mask[i]};
         lane_pc[i]  = {q.if_pc[31:4], 2'(i), 2'b00};
         lane_tgt[i] = q.if_pred_jump[i] ? q.if_pred_target : lane_pc[i] + 32'd4;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + AW'(npop);
         if (push)
            tail <= tail + AW'(npush);
         count <= count + (push ? CW'(npush) : CW'(0)) - CW'(npop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (q.if_mask[i]) begin
               pc_mem[lane_idx[i]]   <= lane_pc[i];
               inst_mem[lane_idx[i]] <= q.if_inst[32*i +: 32];
               tgt_mem[lane_idx[i]]  <= lane_tgt[i];
               pj_mem[lane_idx[i]]   <= q.if_pred_jump[i] & q.if_mask[i];
               excp_mem[lane_idx[i]] <= q.if_excp;
            end
         end
      end
   end

   assign head1 = head + AW'(1);

   assign q.out_pc0          = pc_mem[head];
   assign q.out_pc1          = pc_mem[head1];
   assign q.out_inst0        = inst_mem[head];
   assign q.out_inst1        = inst_mem[head1];
   assign q.out_pred_jump0   = pj_mem[head];
   assign q.out_pred_jump1   = pj_mem[head1];
   assign q.out_pred_target0 = tgt_mem[head];
   assign q.out_pred_target1 = tgt_mem[head1];
   assign q.out_excp0        = excp_mem[head];
   assign q.out_excp1        = excp_mem[head1];
endmodule

// File: tb/tb_inst_queue.sv
// Scoreboard bench for inst_queue: stimulus pushes expected entries, a
// negedge monitor compares the presented head entries and status.
module tb_inst_queue;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned CW    = 5;

   logic          clk   = 1'b0;
   logic          reset = 1'b1;
   logic          flush = 1'b0;
   logic [CW-1:0] count;

   inst_queue_if bus();

   inst_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .q     (bus),
      .count (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      logic [31:0] tgt;
      logic        pj;
      logic        ex;
   } ent_t;

   ent_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      bus.if_valid       = 1'b0;
      bus.if_pc          = '0;
      bus.if_inst        = '0;
      bus.if_mask        = '0;
      bus.if_pred_jump   = '0;
      bus.if_pred_target = '0;
      bus.if_excp        = 1'b0;
      bus.id_pop         = '0;
      flush              = 1'b0;
   endtask

   // One clock of stimulus; the expected queue is updated as the stimulus is issued.
   task automatic step(input logic v, input logic [31:0] pc, input logic [3:0] mask,
                       input logic [3:0] pj, input logic [31:0] tgt, input logic ex,
                       input logic [1:0] pop, input logic fl, input logic [31:0] ibase);
      int unsigned n;
      int unsigned np;
      ent_t e;
      @(negedge clk);
      #1;
      bus.if_valid       = v;
      bus.if_pc          = pc;
      bus.if_inst        = {ibase + 32'd3, ibase + 32'd2, ibase + 32'd1, ibase};
      bus.if_mask        = mask;
      bus.if_pred_jump   = pj;
      bus.if_pred_target = tgt;
      bus.if_excp        = ex;
      bus.id_pop         = pop;
      flush              = fl;
      n = sb.size();
      if (fl) begin
         sb.delete();
      end else begin
         np = ((pop[0] && n >= 1) ? 1 : 0) + ((pop[1] && pop[0] && n >= 2) ? 1 : 0);
         repeat (np) void'(sb.pop_front());
         if (v && n <= DEPTH - 4) begin
            for (int i = 0; i < 4; i++) begin
               if (mask[i]) begin
                  e.pc   = {pc[31:4], 4'(i * 4)};
                  e.inst = ibase + 32'(i);
                  e.pj   = pj[i];
                  e.tgt  = pj[i] ? tgt : e.pc + 32'd4;
                  e.ex   = ex;
                  sb.push_back(e);
               end
            end
         end
      end
      @(posedge clk);
      #2;
      idle_inputs();
   endtask

   always @(negedge clk) begin
      int unsigned n;
      n = sb.size();
      chk("count", 32'(count), n);
      chk("out_valid", {30'b0, bus.out_valid}, {30'b0, n >= 2, n >= 1});
      chk("in_ready", {31'b0, bus.in_ready}, {31'b0, n <= DEPTH - 4});
      if (n >= 1 && bus.out_valid[0]) begin
         chk("pc0", bus.out_pc0, sb[0].pc);
         chk("inst0", bus.out_inst0, sb[0].inst);
         chk("tgt0", bus.out_pred_target0, sb[0].tgt);
         chk("pj0", {31'b0, bus.out_pred_jump0}, {31'b0, sb[0].pj});
         chk("excp0", {31'b0, bus.out_excp0}, {31'b0, sb[0].ex});
      end
      if (n >= 2 && bus.out_valid[1]) begin
         chk("pc1", bus.out_pc1, sb[1].pc);
         chk("inst1", bus.out_inst1, sb[1].inst);
         chk("tgt1", bus.out_pred_target1, sb[1].tgt);
         chk("pj1", {31'b0, bus.out_pred_jump1}, {31'b0, sb[1].pj});
         chk("excp1", {31'b0, bus.out_excp1}, {31'b0, sb[1].ex});
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      idle_inputs();
      repeat (2) @(negedge clk);
      #2;
      reset = 1'b0;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", {30'b0, bus.out_valid}, 32'd0);
      chk("rst_ready", {31'b0, bus.in_ready}, 32'd1);

      // full group, no jump
      step(1, 32'h1c000000, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'h1000);
      chk("s1_count", 32'(count), 32'd4);
      chk("s1_pc0", bus.out_pc0, 32'h1c000000);
      chk("s1_pc1", bus.out_pc1, 32'h1c000004);
      chk("s1_tgt0", bus.out_pred_target0, 32'h1c000004);
      chk("s1_inst0", bus.out_inst0, 32'h00001000);

      // upper two lanes, lane 2 predicted taken
      step(1, 32'h1c000018, 4'b1100, 4'b0100, 32'h1c000100, 0, 2'b00, 0, 32'h2000);
      chk("s2_count", 32'(count), 32'd6);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h0);
      chk("s3_count", 32'(count), 32'd4);
      chk("s3_pc0", bus.out_pc0, 32'h1c000008);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h0);
      chk("s4_count", 32'(count), 32'd2);
      chk("s4_pc0", bus.out_pc0, 32'h1c000018);
      chk("s4_pj0", {31'b0, bus.out_pred_jump0}, 32'd1);
      chk("s4_tgt0", bus.out_pred_target0, 32'h1c000100);
      chk("s4_inst0", bus.out_inst0, 32'h00002002);
      chk("s4_pc1", bus.out_pc1, 32'h1c00001c);
      chk("s4_pj1", {31'b0, bus.out_pred_jump1}, 32'd0);
      chk("s4_tgt1", bus.out_pred_target1, 32'h1c000020);

      // push+pop to walk the tail to slot 14, then push across the wrap
      step(1, 32'h1c000020, 4'b1111, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h3000);
      chk("s5_count", 32'(count), 32'd4);
      step(1, 32'h1c000030, 4'b1111, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h4000);
      chk("s6_count", 32'(count), 32'd6);
      step(1, 32'h1c000040, 4'b1111, 4'b0000, 32'h0, 1, 2'b11, 0, 32'h5000);
      chk("wrap_count", 32'(count), 32'd8);
      chk("wrap_pc0", bus.out_pc0, 32'h1c000030);

      step(1, 32'h1c000050, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'h6000);
      chk("c12_count", 32'(count), 32'd12);
      chk("c12_ready", {31'b0, bus.in_ready}, 32'd1);
      step(1, 32'h1c000060, 4'b0001, 4'b0000, 32'h0, 0, 2'b00, 0, 32'h7000);
      chk("c13_count", 32'(count), 32'd13);
      chk("c13_ready", {31'b0, bus.in_ready}, 32'd0);
      repeat (2) step(1, 32'h1c000070, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'h8000);
      chk("hold_count", 32'(count), 32'd13);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b10, 0, 32'h0);
      chk("pop10_count", 32'(count), 32'd13);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b01, 0, 32'h0);
      chk("pop01_count", 32'(count), 32'd12);
      chk("pop01_ready", {31'b0, bus.in_ready}, 32'd1);
      step(1, 32'h1c000080, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'h9000);
      chk("full_count", 32'(count), 32'd16);
      chk("full_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("full_valid", {30'b0, bus.out_valid}, 32'd3);
      repeat (3) step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h0);
      chk("c10_count", 32'(count), 32'd10);

      // flush beats a simultaneous push and pop
      step(1, 32'h1c000090, 4'b1111, 4'b0000, 32'h0, 0, 2'b11, 1, 32'ha000);
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_valid", {30'b0, bus.out_valid}, 32'd0);
      chk("flush_ready", {31'b0, bus.in_ready}, 32'd1);

      step(1, 32'h1c0000a0, 4'b0110, 4'b0010, 32'h1c000200, 0, 2'b00, 0, 32'hb000);
      chk("mid_count", 32'(count), 32'd2);
      chk("mid_pc0", bus.out_pc0, 32'h1c0000a4);
      chk("mid_tgt0", bus.out_pred_target0, 32'h1c000200);
      chk("mid_tgt1", bus.out_pred_target1, 32'h1c0000ac);
      step(1, 32'h1c0000f0, 4'b0000, 4'b0000, 32'h0, 0, 2'b00, 0, 32'hc000);
      chk("m0_count", 32'(count), 32'd2);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b01, 0, 32'h0);
      step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h0);
      chk("pop2of1_count", 32'(count), 32'd0);

      // asynchronous reset between edges
      step(1, 32'h1c0000b0, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'hd000);
      step(1, 32'h1c0000c0, 4'b1000, 4'b0000, 32'h0, 0, 2'b00, 0, 32'he000);
      chk("pre_rst_count", 32'(count), 32'd5);
      #1;
      reset = 1'b1;
      sb.delete();
      #1;
      chk("arst_count", 32'(count), 32'd0);
      chk("arst_valid", {30'b0, bus.out_valid}, 32'd0);
      chk("arst_ready", {31'b0, bus.in_ready}, 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b0;
      step(1, 32'h1c0000d0, 4'b1111, 4'b0000, 32'h0, 0, 2'b00, 0, 32'hf000);
      chk("resume_count", 32'(count), 32'd4);
      chk("resume_pc0", bus.out_pc0, 32'h1c0000d0);
      repeat (2) step(0, 32'h0, 4'b0000, 4'b0000, 32'h0, 0, 2'b11, 0, 32'h0);
      chk("drain_count", 32'(count), 32'd0);

      @(negedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
